// File: rtl/fifo_ddr_write_sched_if.sv
`default_nettype none
// ==========================================================================
// fifo_ddr_write_sched_if : DDR burst command + write-data channel bundle
// Rev 1.0
// ==========================================================================
interface fifo_ddr_write_sched_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic              o_cmd_valid;
  logic              i_cmd_ready;
  logic [ADDR_W-1:0] o_cmd_addr;
  logic [7:0]        o_cmd_len;
  logic              o_wr_valid;
  logic              i_wr_ready;
  logic [DATA_W-1:0] o_wr_data;
  logic              o_wr_last;

  modport master (
    output o_cmd_valid, o_cmd_addr, o_cmd_len, o_wr_valid, o_wr_data, o_wr_last,
    input  i_cmd_ready, i_wr_ready
  );

  modport slave (
    input  o_cmd_valid, o_cmd_addr, o_cmd_len, o_wr_valid, o_wr_data, o_wr_last,
    output i_cmd_ready, i_wr_ready
  );
endinterface
`default_nettype wire

// File: rtl/fifo_ddr_write_sched.sv
`default_nettype none
// ==========================================================================
// fifo_ddr_write_sched : drains a FWFT word FIFO into DDR write bursts
// Rev 1.0
// ==========================================================================
module fifo_ddr_write_sched #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 24,
  parameter int CNT_W        = 10,
  parameter int BURST_LEN    = 16,
  parameter int BASE_ADDR    = 0,
  parameter int REGION_WORDS = 4096,
  parameter int TIMEOUT      = 1000
) (
  input  wire logic              i_clk,
  input  wire logic              i_rst,
  input  wire logic              i_enable,
  input  wire logic              i_fifo_empty,
  input  wire logic [CNT_W-1:0]  i_fifo_count,
  input  wire logic [DATA_W-1:0] i_fifo_data,
  output logic                   o_fifo_rd_en,
  fifo_ddr_write_sched_if.master ddr,
  output logic                   o_busy,
  output logic                   o_wrap,
  output logic [31:0]            o_words_written
);

  localparam int XW = ((ADDR_W > CNT_W) ? ADDR_W : CNT_W) + 2;
  localparam int IW = $clog2(TIMEOUT) + 1;
  localparam logic [XW-1:0]     BURST_X    = XW'(BURST_LEN);
  localparam logic [XW-1:0]     END_X      = XW'(BASE_ADDR + REGION_WORDS);
  localparam logic [ADDR_W-1:0] BASE_A     = ADDR_W'(BASE_ADDR);
  localparam logic [IW-1:0]     IDLE_LIMIT = IW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [7:0]        beat_q;
  logic [IW-1:0]     idle_cnt_q;
  logic [31:0]       words_q;
  logic              cmd_valid_q;
  logic              wrap_q;
  logic              busy_q;

  logic [XW-1:0] w_cnt_x;
  logic [XW-1:0] w_rem_x;
  logic [XW-1:0] w_len_x;
  logic [XW-1:0] w_next_x;
  logic [7:0]    len_d;
  logic          w_trigger;
  logic          w_in_data;
  logic          w_wr_valid;
  logic          w_beat_acc;
  logic          w_last;

  // Burst length is clipped by fill level and by the words left before the ring end.
  always_comb begin
    w_cnt_x  = XW'(i_fifo_count);
    w_rem_x  = END_X - XW'(addr_q);
    w_len_x  = BURST_X;
    if (w_cnt_x < w_len_x) w_len_x = w_cnt_x;
    if (w_rem_x < w_len_x) w_len_x = w_rem_x;
    w_next_x = XW'(addr_q) + XW'(len_q);
  end

  assign len_d      = 8'(w_len_x);
  assign w_trigger  = i_enable && ((w_cnt_x >= BURST_X) ||
                      ((i_fifo_count != '0) && (idle_cnt_q == IDLE_LIMIT)));
  // Reset gates the data channel so an abandoned burst pops nothing further.
  assign w_in_data  = (state_q == DATA) && !i_rst;
  assign w_wr_valid = w_in_data && !i_fifo_empty;
  assign w_beat_acc = w_wr_valid && ddr.i_wr_ready;
  assign w_last     = w_in_data && (beat_q == (len_q - 8'd1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      addr_q      <= BASE_A;
      len_q       <= 8'd0;
      beat_q      <= 8'd0;
      idle_cnt_q  <= '0;
      words_q     <= 32'd0;
      cmd_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      case (state_q)
        IDLE: begin
          len_q <= len_d;
          if (w_trigger) begin
            state_q     <= CMD;
            cmd_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            idle_cnt_q  <= '0;
          end else if (!i_enable || (i_fifo_count == '0)) begin
            idle_cnt_q <= '0;
          end else if (w_cnt_x < BURST_X) begin
            idle_cnt_q <= idle_cnt_q + IW'(1);
          end
        end
        CMD: begin
          if (ddr.i_cmd_ready) begin
            state_q     <= DATA;
            cmd_valid_q <= 1'b0;
            beat_q      <= 8'd0;
          end
        end
        DATA: begin
          if (w_beat_acc) begin
            beat_q  <= beat_q + 8'd1;
            words_q <= words_q + 32'd1;
            if (w_last) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              if (w_next_x == END_X) begin
                addr_q <= BASE_A;
                wrap_q <= 1'b1;
              end else begin
                addr_q <= ADDR_W'(w_next_x);
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ddr.o_cmd_valid = cmd_valid_q;
  assign ddr.o_cmd_addr  = addr_q;
  assign ddr.o_cmd_len   = len_q;
  assign ddr.o_wr_valid  = w_wr_valid;
  assign ddr.o_wr_data   = i_fifo_data;
  assign ddr.o_wr_last   = w_last;
  assign o_fifo_rd_en    = w_beat_acc;
  assign o_busy          = busy_q;
  assign o_wrap          = wrap_q;
  assign o_words_written = words_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_ddr_write_sched.sv
`default_nettype none
// ==========================================================================
// tb_fifo_ddr_write_sched : scoreboard bench with a FWFT FIFO model
// Rev 1.0
// ==========================================================================
module tb_fifo_ddr_write_sched;
  localparam int DATA_W       = 16;
  localparam int ADDR_W       = 24;
  localparam int CNT_W        = 10;
  localparam int BURST_LEN    = 16;
  localparam int REGION_WORDS = 40;
  localparam int TIMEOUT      = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst    = 1'b1;
  logic              enable = 1'b0;
  logic              stall  = 1'b0;
  logic              fq_empty_r = 1'b1;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count = '0;
  logic [DATA_W-1:0] fifo_data  = '0;
  logic              fifo_rd_en;
  logic              busy;
  logic              wrap;
  logic [31:0]       words;

  fifo_ddr_write_sched_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ddr ();

  fifo_ddr_write_sched #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .BURST_LEN(BURST_LEN),
    .BASE_ADDR(0), .REGION_WORDS(REGION_WORDS), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_fifo_empty(fifo_empty),
    .i_fifo_count(fifo_count), .i_fifo_data(fifo_data), .o_fifo_rd_en(fifo_rd_en),
    .ddr(ddr), .o_busy(busy), .o_wrap(wrap), .o_words_written(words)
  );

  assign fifo_empty = stall | fq_empty_r;

  logic [DATA_W-1:0]   fq[$];
  logic [DATA_W-1:0]   exp_data[$];
  logic [ADDR_W+7:0]   exp_cmd[$];
  int checks = 0, failures = 0;
  int pop_cnt = 0, cmd_cnt = 0, wrap_cnt = 0, mon_beat = 0, mon_len = 0;

  // FWFT FIFO model: pops and status refresh on the clock edge
  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0) void'(fq.pop_front());
    fq_empty_r <= (fq.size() == 0);
    fifo_count <= CNT_W'(fq.size());
    fifo_data  <= (fq.size() > 0) ? fq[0] : '0;
  end

  // Scoreboard: commands and data beats are popped from the expectation queues
  always @(posedge clk) begin
    logic [ADDR_W+7:0] e;
    logic [DATA_W-1:0] d;
    if (rst) begin
      mon_beat = 0;
    end else begin
      checks++;
      if (ddr.o_cmd_valid && ddr.o_wr_valid) begin
        failures++;
        $display("FAIL chan_excl: cmd_valid=1 wr_valid=1, required not both");
      end
      checks++;
      if (fifo_rd_en !== (ddr.o_wr_valid && ddr.i_wr_ready)) begin
        failures++;
        $display("FAIL rd_en: got %0b required %0b", fifo_rd_en, ddr.o_wr_valid && ddr.i_wr_ready);
      end
      if (ddr.o_cmd_valid && ddr.i_cmd_ready) begin
        cmd_cnt++;
        checks++;
        if (exp_cmd.size() == 0) begin
          failures++;
          $display("FAIL cmd_unexpected: got addr=%0d len=%0d, required none", ddr.o_cmd_addr, ddr.o_cmd_len);
        end else begin
          e = exp_cmd.pop_front();
          if ({ddr.o_cmd_addr, ddr.o_cmd_len} !== e) begin
            failures++;
            $display("FAIL cmd: got addr=%0d len=%0d required addr=%0d len=%0d",
                     ddr.o_cmd_addr, ddr.o_cmd_len, e[ADDR_W+7:8], e[7:0]);
          end
          mon_len = int'(e[7:0]);
        end
        mon_beat = 0;
      end
      if (ddr.o_wr_valid && ddr.i_wr_ready) begin
        pop_cnt++;
        checks++;
        if (exp_data.size() == 0) begin
          failures++;
          $display("FAIL data_unexpected: got %h required none", ddr.o_wr_data);
        end else begin
          d = exp_data.pop_front();
          if (ddr.o_wr_data !== d) begin
            failures++;
            $display("FAIL data: got %h required %h", ddr.o_wr_data, d);
          end
        end
        checks++;
        if (ddr.o_wr_last !== (mon_beat == mon_len - 1)) begin
          failures++;
          $display("FAIL wr_last: beat %0d got %0b required %0b", mon_beat, ddr.o_wr_last, mon_beat == mon_len - 1);
        end
        mon_beat++;
      end
      if (wrap) wrap_cnt++;
    end
  end

  task automatic push_words(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      fq.push_back(DATA_W'(start + i));
      exp_data.push_back(DATA_W'(start + i));
    end
  endtask

  task automatic expect_cmd(input int addr, input int len);
    exp_cmd.push_back({ADDR_W'(addr), 8'(len)});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; stall = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_cmd.size() == 0 && exp_data.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_timeout: cmds left=%0d words left=%0d busy=%0b, required 0 0 0",
               name, exp_cmd.size(), exp_data.size(), busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({busy, ddr.o_cmd_valid, ddr.o_wr_valid, ddr.o_wr_last, fifo_rd_en, wrap} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b required 000000",
               {busy, ddr.o_cmd_valid, ddr.o_wr_valid, ddr.o_wr_last, fifo_rd_en, wrap});
    end
    checks++;
    if (words !== 32'd0) begin
      failures++;
      $display("FAIL reset_words: got %0d required 0", words);
    end
  endtask

  task automatic test_full_burst();
    ddr.i_cmd_ready = 1'b1;
    ddr.i_wr_ready  = 1'b1;
    push_words(1, 16);
    expect_cmd(0, 16);
    repeat (2) @(negedge clk);
    enable = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ddr.o_cmd_valid !== 1'b1 || ddr.o_cmd_addr !== 24'd0 || ddr.o_cmd_len !== 8'd16) begin
      failures++;
      $display("FAIL full_cmd: got valid=%0b addr=%0d len=%0d required 1 0 16",
               ddr.o_cmd_valid, ddr.o_cmd_addr, ddr.o_cmd_len);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (ddr.o_wr_valid !== 1'b1 || ddr.o_wr_data !== DATA_W'(i + 1)) begin
        failures++;
        $display("FAIL full_stream beat %0d: got valid=%0b data=%h required 1 %h",
                 i, ddr.o_wr_valid, ddr.o_wr_data, DATA_W'(i + 1));
      end
      if (i == 15) begin
        checks++;
        if (ddr.o_wr_last !== 1'b1) begin
          failures++;
          $display("FAIL full_last: got %0b required 1", ddr.o_wr_last);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (busy !== 1'b0 || words !== 32'd16) begin
      failures++;
      $display("FAIL full_done: got busy=%0b words=%0d required 0 16", busy, words);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    push_words(17, 16);
    expect_cmd(16, 16);
    wait_idle(100, "b2b");
    checks++;
    if (words !== 32'd32) begin
      failures++;
      $display("FAIL b2b_words: got %0d required 32", words);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    int base;
    do_reset();
    enable = 1'b1;
    expect_cmd(0, 5);
    push_words(16'h100, 5);
    @(posedge clk);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      n++;
      if (ddr.o_cmd_valid) break;
    end
    checks++;
    if (n !== TIMEOUT) begin
      failures++;
      $display("FAIL timeout_delay: got %0d cycles required %0d", n, TIMEOUT);
    end
    wait_idle(100, "timeout");
    base = cmd_cnt;
    repeat (30) @(negedge clk);
    checks++;
    if (cmd_cnt !== base || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_quiet: got %0d extra cmds busy=%0b required 0 0", cmd_cnt - base, busy);
    end
    push_words(16'h110, 16);
    expect_cmd(5, 16);
    wait_idle(100, "timeout_next");
  endtask

  task automatic test_backpressure();
    int base;
    bit seen = 1'b0;
    do_reset();
    ddr.i_cmd_ready = 1'b0;
    ddr.i_wr_ready  = 1'b0;
    push_words(16'h200, 16);
    expect_cmd(0, 16);
    @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ddr.o_cmd_valid) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL bp_cmd_wait: got cmd_valid=0 required 1");
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (ddr.o_cmd_valid !== 1'b1 || ddr.o_cmd_addr !== 24'd0 || ddr.o_cmd_len !== 8'd16 || fifo_rd_en !== 1'b0) begin
        failures++;
        $display("FAIL bp_cmd_hold: got valid=%0b addr=%0d len=%0d rd_en=%0b required 1 0 16 0",
                 ddr.o_cmd_valid, ddr.o_cmd_addr, ddr.o_cmd_len, fifo_rd_en);
      end
    end
    base = pop_cnt;
    ddr.i_cmd_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ddr.i_wr_ready = ~ddr.i_wr_ready;
      if (pop_cnt - base == 16 && !busy) break;
    end
    ddr.i_wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (pop_cnt - base !== 16) begin
      failures++;
      $display("FAIL bp_pops: got %0d required 16", pop_cnt - base);
    end
  endtask

  task automatic test_region_wrap();
    int wbase;
    do_reset();
    wbase = wrap_cnt;
    expect_cmd(0, 16); expect_cmd(16, 16); expect_cmd(32, 8);
    expect_cmd(0, 16); expect_cmd(16, 8);
    push_words(16'h1000, 64);
    enable = 1'b1;
    wait_idle(400, "wrap");
    checks++;
    if (wrap_cnt - wbase !== 1) begin
      failures++;
      $display("FAIL wrap_pulses: got %0d required 1", wrap_cnt - wbase);
    end
    checks++;
    if (words !== 32'd64) begin
      failures++;
      $display("FAIL wrap_words: got %0d required 64", words);
    end
  endtask

  task automatic test_underrun();
    int base;
    do_reset();
    push_words(16'h300, 16);
    expect_cmd(0, 16);
    enable = 1'b1;
    base = pop_cnt;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pop_cnt - base == 6) break;
    end
    stall = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (ddr.o_wr_valid !== 1'b0 || fifo_rd_en !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL underrun_gap: got valid=%0b rd_en=%0b busy=%0b required 0 0 1",
                 ddr.o_wr_valid, fifo_rd_en, busy);
      end
    end
    checks++;
    if (pop_cnt - base !== 6) begin
      failures++;
      $display("FAIL underrun_pops: got %0d required 6", pop_cnt - base);
    end
    stall = 1'b0;
    wait_idle(100, "underrun");
    checks++;
    if (pop_cnt - base !== 16) begin
      failures++;
      $display("FAIL underrun_total: got %0d required 16", pop_cnt - base);
    end
  endtask

  task automatic test_reset_mid_data();
    int base;
    do_reset();
    push_words(16'h400, 16);
    expect_cmd(0, 16);
    enable = 1'b1;
    wait_idle(100, "rst_pre");
    push_words(16'h500, 16);
    expect_cmd(16, 16);
    base = pop_cnt;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pop_cnt - base == 3) break;
    end
    rst = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, ddr.o_cmd_valid, ddr.o_wr_valid, fifo_rd_en, wrap} !== 5'b0 || words !== 32'd0) begin
      failures++;
      $display("FAIL rst_mid: got flags=%b words=%0d required 00000 0",
               {busy, ddr.o_cmd_valid, ddr.o_wr_valid, fifo_rd_en, wrap}, words);
    end
    rst = 1'b0;
    checks++;
    if (pop_cnt - base !== 3) begin
      failures++;
      $display("FAIL rst_pops: got %0d required 3", pop_cnt - base);
    end
    push_words(16'h600, 3);
    expect_cmd(0, 16);
    @(negedge clk);
    enable = 1'b1;
    wait_idle(100, "rst_post");
    checks++;
    if (words !== 32'd16) begin
      failures++;
      $display("FAIL rst_post_words: got %0d required 16", words);
    end
  endtask

  initial begin
    ddr.i_cmd_ready = 1'b1;
    ddr.i_wr_ready  = 1'b1;
    test_reset();
    test_full_burst();
    test_back_to_back();
    test_timeout();
    test_backpressure();
    test_region_wrap();
    test_underrun();
    test_reset_mid_data();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
